// File: rtl/jtdd_scan2x.sv
// rtl/jtdd_scan2x.sv - 15 kHz to 31 kHz line-doubling scan converter (optional JTDD_SCAN2X_SCANLINES_EN)
module jtdd_scan2x #(
  parameter int DW   = 12,
  parameter int AW   = 9,
  parameter int HS_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          pxl2_cen,
  input  logic [DW-1:0] rgb_in,
  input  logic          LHBL,
  input  logic          LVBL,
  input  logic          HS_in,
  input  logic          VS_in,
  output logic [DW-1:0] rgb_out,
  output logic          LHBL_out,
  output logic          LVBL_out,
  output logic          HS_out,
  output logic          VS_out,
  output logic          valid
);

  localparam logic [AW-1:0] MAX    = '1;
  localparam logic [AW-1:0] MAX_M1 = MAX - 1'b1;
  localparam logic [AW-1:0] HS_END = AW'(HS_W);
  localparam int            CW     = DW / 3;

  logic          hs_l;
  logic          hs_re;
  logic          hs_tick;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] rcnt;
  logic [AW-1:0] len;
  logic          wbank;
  logic          ovf;
  logic          ovf_rd;
  logic          seen;
  logic          we;
  logic          show;
  logic [AW:0]   rnext;
  logic [DW:0]   ram_q;
  logic [DW-1:0] pix_rgb;

  // two banks of {LHBL, rgb}, bank select is the address MSB
  logic [DW:0] mem [0:2**(AW+1)-1];

  // hs_re stays high for one full pxl_cen period; line events fire on the pxl_cen inside it
  assign hs_tick = pxl_cen & hs_re;
  assign we      = pxl_cen & (wcnt != MAX);
  assign show    = valid & ~ovf_rd;
  assign rnext   = {1'b0, rcnt} + 1'b1;

  // HS rising-edge detector in the pxl_cen domain
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_l  <= 1'b0;
      hs_re <= 1'b0;
    end else if (pxl_cen) begin
      hs_l  <= HS_in;
      hs_re <= HS_in & ~hs_l;
    end
  end

  // write counter, bank swap, line measurement, overflow and vertical timing capture
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      len      <= '0;
      ovf      <= 1'b0;
      ovf_rd   <= 1'b0;
      seen     <= 1'b0;
      valid    <= 1'b0;
      LVBL_out <= 1'b0;
      VS_out   <= 1'b0;
    end else if (pxl_cen) begin
      if (hs_re) begin
        wcnt     <= '0;
        wbank    <= ~wbank;
        len      <= (wcnt == MAX) ? MAX : wcnt + 1'b1;
        ovf_rd   <= ovf;
        ovf      <= 1'b0;
        seen     <= 1'b1;
        valid    <= seen;
        LVBL_out <= LVBL;
        VS_out   <= VS_in;
      end else if (wcnt != MAX) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == MAX_M1) ovf <= 1'b1;
      end
    end
  end

  // line buffer write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem[{wbank, wcnt}] <= {LHBL, rgb_in};
  end

  // line buffer read port, one clk latency, always reading the bank not being written
  always_ff @(posedge clk) begin
    ram_q <= mem[{~wbank, rcnt}];
  end

  // read counter: runs at double rate, wraps at len, re-phased on every input line
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
    end else if (hs_tick) begin
      rcnt <= '0;
    end else if (pxl2_cen) begin
      if (rnext >= {1'b0, len}) rcnt <= '0;
      else                      rcnt <= rnext[AW-1:0];
    end
  end

`ifdef JTDD_SCAN2X_SCANLINES_EN
  logic pass;

  // tracks which readout of the stored line is in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      pass <= 1'b0;
    end else if (hs_tick) begin
      pass <= 1'b0;
    end else if (pxl2_cen && rnext >= {1'b0, len}) begin
      pass <= ~pass;
    end
  end

  // second readout dims each channel to c - c/4
  always_comb begin
    pix_rgb = ram_q[DW-1:0];
    if (pass) begin
      for (int i = 0; i < 3; i++) begin
        pix_rgb[i*CW +: CW] = ram_q[i*CW +: CW] - (ram_q[i*CW +: CW] >> 2);
      end
    end
  end
`else
  assign pix_rgb = ram_q[DW-1:0];
`endif

  // output register, blanked until a line is measured or when the line overflowed
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_out  <= '0;
      LHBL_out <= 1'b0;
      HS_out   <= 1'b0;
    end else if (pxl2_cen) begin
      LHBL_out <= show & ram_q[DW];
      rgb_out  <= (show & ram_q[DW]) ? pix_rgb : '0;
      HS_out   <= show & (rcnt < HS_END);
    end
  end

endmodule

// File: tb/tb_jtdd_scan2x.sv
// tb/tb_jtdd_scan2x.sv - scoreboard bench for jtdd_scan2x
module tb_jtdd_scan2x;

  logic        clk = 1'b0;
  logic        rst;
  logic        pxl_cen;
  logic        pxl2_cen;
  logic [11:0] rgb_in;
  logic        LHBL;
  logic        LVBL;
  logic        HS_in;
  logic        VS_in;
  logic [11:0] rgb_out;
  logic        LHBL_out;
  logic        LVBL_out;
  logic        HS_out;
  logic        VS_out;
  logic        valid;

`ifdef JTDD_SCAN2X_SCANLINES_EN
  localparam bit DIM_EN = 1'b1;
`else
  localparam bit DIM_EN = 1'b0;
`endif

  jtdd_scan2x #(.DW(12), .AW(9), .HS_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .pxl2_cen (pxl2_cen),
    .rgb_in   (rgb_in),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .HS_in    (HS_in),
    .VS_in    (VS_in),
    .rgb_out  (rgb_out),
    .LHBL_out (LHBL_out),
    .LVBL_out (LVBL_out),
    .HS_out   (HS_out),
    .VS_out   (VS_out),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] exp_q [$];
  logic [12:0] prev_mem [0:511];
  int          prev_len = 0;
  bit          prev_show = 1'b0;
  logic        prev_vs = 1'b0;
  logic        prev_lvbl = 1'b0;
  int          line_cnt = 0;
  int          tick_k = 0;

  function automatic logic [11:0] dim(input logic [11:0] c);
    logic [11:0] d;
    for (int i = 0; i < 3; i++) d[i*4 +: 4] = c[i*4 +: 4] - (c[i*4 +: 4] >> 2);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic pc, input logic p2);
    logic [15:0] e;
    pxl_cen  = pc;
    pxl2_cen = p2;
    @(negedge clk);
    pxl_cen  = 1'b0;
    pxl2_cen = 1'b0;
    if (p2) begin
      tick_k++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL scoreboard_empty line=%0d tick=%0d observed=%h expected=none", line_cnt, tick_k,
               {rgb_out, LHBL_out, LVBL_out, HS_out, VS_out});
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("tick line=%0d k=%0d {rgb,lhbl,lvbl,hs,vs}", line_cnt, tick_k),
            {rgb_out, LHBL_out, LVBL_out, HS_out, VS_out}, e);
      end
    end
  endtask

  task automatic drive_line(input int n, input logic [3:0] seed, input int blank_px,
                            input logic vs, input logic lvbl, input logic white);
    logic [12:0] cur [0:1023];
    logic [3:0]  jj;
    logic [12:0] ent;
    logic [11:0] c;
    logic        lh;
    logic        hs;
    int          r;
    int          pass;
    for (int j = 0; j < n; j++) begin
      jj     = j[3:0] ^ seed;
      cur[j] = {(j >= blank_px), (white ? 12'hFFF : {jj, jj, jj})};
    end
    // expected output while this line is written: the previous line shown twice
    for (int k = 1; k <= 2 * n; k++) begin
      c  = 12'h000;
      lh = 1'b0;
      hs = 1'b0;
      if (prev_show && prev_len > 0) begin
        r    = (k - 1) % prev_len;
        pass = ((k - 1) / prev_len) % 2;
        ent  = prev_mem[r];
        lh   = ent[12];
        hs   = (r < 16);
        if (lh) c = (DIM_EN && pass == 1) ? dim(ent[11:0]) : ent[11:0];
      end
      exp_q.push_back({c, lh, (k == 2 * n) ? lvbl : prev_lvbl, hs, (k == 2 * n) ? vs : prev_vs});
    end
    tick_k = 0;
    for (int j = 0; j < n; j++) begin
      rgb_in = cur[j][11:0];
      LHBL   = cur[j][12];
      HS_in  = (j == n - 2);
      VS_in  = vs;
      LVBL   = lvbl;
      cyc(1'b0, 1'b1);
      cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
    end
    for (int a = 0; a < 511 && a < n; a++) prev_mem[a] = cur[a];
    prev_len  = (n > 511) ? 511 : n;
    prev_show = (line_cnt >= 1) && (n <= 511);
    prev_vs   = vs;
    prev_lvbl = lvbl;
    line_cnt++;
    chk($sformatf("valid after line %0d", line_cnt), {15'd0, valid}, {15'd0, (line_cnt >= 2)});
  endtask

  initial begin
    rst      = 1'b1;
    pxl_cen  = 1'b0;
    pxl2_cen = 1'b0;
    rgb_in   = 12'h000;
    LHBL     = 1'b1;
    LVBL     = 1'b1;
    HS_in    = 1'b0;
    VS_in    = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rgb_out", {4'd0, rgb_out}, 16'h0000);
    chk("reset LHBL_out", {15'd0, LHBL_out}, 16'h0000);
    chk("reset LVBL_out", {15'd0, LVBL_out}, 16'h0000);
    chk("reset HS_out", {15'd0, HS_out}, 16'h0000);
    chk("reset VS_out", {15'd0, VS_out}, 16'h0000);
    chk("reset valid", {15'd0, valid}, 16'h0000);

    drive_line(384, 4'h0, 0, 1'b0, 1'b1, 1'b0);
    drive_line(384, 4'h0, 0, 1'b0, 1'b1, 1'b0);
    chk("len steady", {7'd0, dut.len}, 16'd384);
    drive_line(384, 4'h5, 0, 1'b0, 1'b1, 1'b0);
    drive_line(384, 4'h0, 64, 1'b0, 1'b1, 1'b0);
    drive_line(384, 4'h9, 0, 1'b0, 1'b1, 1'b0);
    drive_line(600, 4'h3, 0, 1'b0, 1'b1, 1'b0);
    chk("len saturated", {7'd0, dut.len}, 16'd511);
    drive_line(384, 4'h6, 0, 1'b0, 1'b1, 1'b0);
    chk("len recovered", {7'd0, dut.len}, 16'd384);
    drive_line(384, 4'h0, 0, 1'b0, 1'b1, 1'b1);
    drive_line(384, 4'h2, 0, 1'b0, 1'b1, 1'b0);
    drive_line(384, 4'h7, 0, 1'b1, 1'b0, 1'b0);
    drive_line(384, 4'hA, 0, 1'b1, 1'b0, 1'b0);
    drive_line(384, 4'hC, 0, 1'b1, 1'b0, 1'b0);
    drive_line(384, 4'h1, 0, 1'b0, 1'b1, 1'b0);
    drive_line(384, 4'hE, 0, 1'b0, 1'b1, 1'b0);
    chk("scoreboard drained", exp_q.size() == 0 ? 16'd0 : 16'd1, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdd_scan2x.md
Name: jtdd_scan2x

Overview:
- Line-doubling scan converter directly downstream of the DD video stage.
- Consumes the 15 kHz pixel stream after credits overlay: 12-bit RGB, active-low blanks, syncs.
- Emits a 31 kHz stream: each input line is stored in one half of a ping-pong line buffer and read out twice at double pixel rate from the other half.
- Feeds the frame-level video output/scaler logic.

Parameters:
- DW, 12, pixel colour width ({r,g,b} 4 bits each).
- AW, 9, line buffer address width; maximum measurable line length is 2^AW-1 pixels.
- HS_W, 16, output HS pulse width in pxl2_cen ticks.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pxl_cen  input  1  input pixel clock enable.
- pxl2_cen  input  1  double-rate pixel clock enable; exactly two per pxl_cen period.
- rgb_in  input  DW  input pixel colour.
- LHBL  input  1  input horizontal blank, active low.
- LVBL  input  1  input vertical blank, active low.
- HS_in  input  1  input horizontal sync, active high.
- VS_in  input  1  input vertical sync, active high.
- rgb_out  output  DW  doubled pixel colour; 0 while blanked.
- LHBL_out  output  1  output horizontal blank, active low.
- LVBL_out  output  1  output vertical blank, active low.
- HS_out  output  1  output horizontal sync, active high.
- VS_out  output  1  output vertical sync, active high.
- valid  output  1  high once a complete input line length has been measured.

Behaviour:
- HS edge: HS_in is sampled on pxl_cen. A rising edge (hs_re) is a registered pulse, one pxl_cen wide.
- Write side:
  - wcnt (AW bits) increments on each pxl_cen and resets to 0 on hs_re.
  - Each pxl_cen writes {LHBL, rgb_in} to bank wbank at address wcnt.
  - wbank toggles on hs_re.
  - When wcnt reaches 2^AW-1 it saturates and writes stop. This sets a sticky ovf flag, cleared on the next hs_re.
- Line length:
  - On hs_re, len <= wcnt+1 (saturating at 2^AW-1).
  - valid goes high on the second hs_re after reset, when the first full line has been measured.
- Read side:
  - rcnt (AW bits) increments on each pxl2_cen and wraps to 0 at len-1. This gives two output lines per input line.
  - rcnt is forced to 0 on hs_re (phase lock). If hs_re coincides with pxl2_cen, the reset wins.
  - Reads come from bank ~wbank at rcnt.
  - RAM read latency is 1 clk; the output register updates on the following pxl2_cen.
  - Total pipeline latency from rcnt to outputs is 1 pxl2_cen tick.
- Outputs:
  - HS_out = 1 while the registered rcnt < HS_W.
  - LHBL_out = stored LHBL bit.
  - rgb_out = LHBL_out ? stored rgb : 0.
  - LVBL_out and VS_out register LVBL and VS_in on hs_re, so vertical timing changes only at input-line boundaries.
- While valid=0, or while ovf is set for the line being read: rgb_out=0, LHBL_out=0, HS_out=0.
- Reset values: rgb_out=0, LHBL_out=0, LVBL_out=0, HS_out=0, VS_out=0, valid=0, wcnt=rcnt=len=0, wbank=0, ovf=0.
- Reset mid-line: all counters clear and valid drops; buffer RAM contents are not cleared.
- Line length changing between lines: the new len applies from the hs_re that measured it; no glitch beyond a truncated or extended last output line.

Optional Feature:
- Macro: JTDD_SCAN2X_SCANLINES_EN.
- Defined: on the second readout of each stored line (second pass of rcnt), each 4-bit channel is output as c - (c>>2), truncated. The first readout is unchanged.
- Undefined: both readouts are identical; no dimming logic is synthesised.

Test Plan:
- Reset held 4 clk, then released → all outputs 0, valid=0 until the second hs_re.
- Steady 384-pixel lines, pixel value = wcnt[3:0] replicated per channel:
  - valid rises at the 2nd HS edge; len=384.
  - Each stored line appears twice, 384 pxl2_cen ticks apart.
  - HS_out pulses 16 ticks at rcnt 0.
- LHBL low for pixels 0..63 → LHBL_out low and rgb_out=0 for rcnt 0..63 on both readouts; rgb_out=12'h333 at rcnt=3 is never output.
- Line of 600 pixels with AW=9:
  - wcnt saturates at 511 and ovf is set.
  - That line's readout is blanked with HS_out=0.
  - Next 384-pixel line recovers normally.
- VS_in high for 3 input lines → VS_out high for exactly 6 output lines, changing only at hs_re.
- JTDD_SCAN2X_SCANLINES_EN defined, input 12'hFFF → first readout 12'hFFF, second 12'hCCC; macro undefined → both readouts 12'hFFF.
